// File: rtl/rice_bus_memory_responder.sv
// rice_bus_memory_responder
//   Byte-addressable memory behind a valid/ready request port.
//   Each accepted request gets exactly one response, queued in a 2-entry
//   in-order FIFO. Read data is captured at the accept edge.
//
// Parameters
//   ADDRESS_WIDTH  request address width
//   DATA_WIDTH     data width (power of two, >= 8)
//   BASE_ADDRESS   first decoded byte address
//   SIZE           storage bytes (power of two, multiple of DATA_WIDTH/8)
//
// Ports
//   i_clk, i_rst                    clock (rising edge), async active-high reset
//   i_request_valid/o_request_ready request handshake
//   i_address, i_write              byte address, 1=write 0=read
//   i_write_data, i_strobe          write data and byte-lane enables
//   o_response_valid/i_response_ready response handshake
//   o_read_data, o_error            response payload, zero when not valid
module rice_bus_memory_responder #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned BASE_ADDRESS  = 0,
  parameter int unsigned SIZE          = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_request_valid,
  output logic                    o_request_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                    i_write,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic [DATA_WIDTH/8-1:0] i_strobe,
  output logic                    o_response_valid,
  input  logic                    i_response_ready,
  output logic [DATA_WIDTH-1:0]   o_read_data,
  output logic                    o_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int WORDS = SIZE / BYTES;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW1   = ADDRESS_WIDTH + 1;

  // Range limits carry one extra bit so BASE_ADDRESS+SIZE cannot wrap.
  localparam logic [AW1-1:0] BASE_EXT  = AW1'(BASE_ADDRESS);
  localparam logic [AW1-1:0] LIMIT_EXT = AW1'(BASE_ADDRESS) + AW1'(SIZE);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } resp_t;

  logic [DATA_WIDTH-1:0]    mem [WORDS];
  logic [AW1-1:0]           addr_ext;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         word_idx;
  logic                     in_range;
  logic                     accept, push, pop;
  resp_t                    resp_new;

  resp_t       fifo [2];
  logic [1:0]  count, count_next;
  logic        wr_ptr, rd_ptr;
  logic        ready_q;

  // ---------------- decode ----------------
  assign addr_ext = {1'b0, i_address};
  assign in_range = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
  assign offset   = i_address - BASE_EXT[ADDRESS_WIDTH-1:0];
  assign word_idx = IDX_W'(offset >> LSB);

  assign accept = i_request_valid & ready_q;
  assign push   = accept;
  assign pop    = (count != 2'd0) & i_response_ready;

  // ---------------- storage (never reset) ----------------
  always_ff @(posedge i_clk) begin
    if (accept && i_write && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_strobe[b]) mem[word_idx][b*8 +: 8] <= i_write_data[b*8 +: 8];
      end
    end
  end

  // Reads sample storage before this edge's update, so a write on the
  // previous edge is already visible here.
  always_comb begin
    resp_new      = '0;
    resp_new.err  = ~in_range;
    if (in_range && !i_write) resp_new.data = mem[word_idx];
  end

  // ---------------- response FIFO ----------------
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo[wr_ptr] <= resp_new;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      // Ready is a pure register: full-ness is known one edge ahead.
      ready_q <= (count_next != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  assign o_request_ready  = ready_q;
  assign o_response_valid = (count != 2'd0);
  assign o_read_data      = o_response_valid ? fifo[rd_ptr].data : '0;
  assign o_error          = o_response_valid ? fifo[rd_ptr].err  : 1'b0;

endmodule

// File: tb/tb_rice_bus_memory_responder.sv
// Directed self-checking bench for rice_bus_memory_responder (default params).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rice_bus_memory_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] address = '0;
  logic        write = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  strobe = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  rice_bus_memory_responder dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_request_valid (req_valid),
    .o_request_ready (req_ready),
    .i_address       (address),
    .i_write         (write),
    .i_write_data    (wdata),
    .i_strobe        (strobe),
    .o_response_valid(resp_valid),
    .i_response_ready(resp_ready),
    .o_read_data     (rdata),
    .o_error         (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid = v;
    write     = w;
    address   = a;
    wdata     = d;
    strobe    = s;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", resp_valid); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rst_payload got %h/%b exp 0/0", rdata, err); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_write_read;
    resp_ready = 1'b1;
    set_req(1, 1, 32'h10, 32'h12345678, 4'hF);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_pre_valid got %b exp 0", resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL wr_resp got v=%b %h/%b exp v=1 0/0", resp_valid, rdata, err); end
    set_req(1, 0, 32'h10, 32'h0, 4'h0);
    tick();
    checks++; if (resp_valid !== 1'b1 || rdata !== 32'h12345678 || err !== 1'b0) begin
      errors++; $display("FAIL rd_resp got v=%b %h/%b exp v=1 12345678/0", resp_valid, rdata, err); end
    set_req(0, 0, 32'h0, 32'h0, 4'h0);
    tick();
    checks++; if (resp_valid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL idle_resp got v=%b %h/%b exp v=0 0/0", resp_valid, rdata, err); end
  endtask

  task automatic test_strobe;
    resp_ready = 1'b1;
    set_req(1, 1, 32'h20, 32'hAABBCCDD, 4'hF); tick();
    set_req(1, 1, 32'h20, 32'h11223344, 4'h5); tick();
    set_req(1, 0, 32'h20, 32'h0, 4'h0);        tick();
    checks++; if (rdata !== 32'hAA22CC44 || err !== 1'b0) begin
      errors++; $display("FAIL strobe5 got %h/%b exp aa22cc44/0", rdata, err); end
    set_req(1, 1, 32'h22, 32'hFFFFFFFF, 4'h0); tick();
    checks++; if (resp_valid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL strobe0_resp got v=%b %h/%b exp v=1 0/0", resp_valid, rdata, err); end
    set_req(1, 0, 32'h23, 32'h0, 4'h0); tick();
    checks++; if (rdata !== 32'hAA22CC44) begin
      errors++; $display("FAIL strobe0_keep got %h exp aa22cc44", rdata); end
    set_req(0, 0, 32'h0, 32'h0, 4'h0); tick();
  endtask

  task automatic test_out_of_range;
    resp_ready = 1'b1;
    set_req(1, 1, 32'hFFC, 32'hCAFEF00D, 4'hF); tick();
    set_req(1, 0, 32'h1000, 32'h0, 4'h0);       tick();
    checks++; if (resp_valid !== 1'b1 || rdata !== 32'h0 || err !== 1'b1) begin
      errors++; $display("FAIL oor_read got v=%b %h/%b exp v=1 0/1", resp_valid, rdata, err); end
    set_req(1, 1, 32'h1000, 32'hDEADBEEF, 4'hF); tick();
    checks++; if (rdata !== 32'h0 || err !== 1'b1) begin
      errors++; $display("FAIL oor_write got %h/%b exp 0/1", rdata, err); end
    set_req(1, 0, 32'hFFF, 32'h0, 4'h0); tick();
    checks++; if (rdata !== 32'hCAFEF00D || err !== 1'b0) begin
      errors++; $display("FAIL last_word got %h/%b exp cafef00d/0", rdata, err); end
    set_req(1, 0, 32'h0, 32'h0, 4'h0); tick();
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL first_word_err got %b exp 0", err); end
    set_req(0, 0, 32'h0, 32'h0, 4'h0); tick();
  endtask

  task automatic test_backpressure;
    resp_ready = 1'b1;
    set_req(1, 1, 32'h40, 32'h1, 4'hF); tick();
    set_req(1, 1, 32'h44, 32'h2, 4'hF); tick();
    set_req(1, 1, 32'h48, 32'h3, 4'hF); tick();
    set_req(0, 0, 32'h0, 32'h0, 4'h0);  tick();
    resp_ready = 1'b0;
    set_req(1, 0, 32'h40, 32'h0, 4'h0); tick();
    checks++; if (req_ready !== 1'b1 || rdata !== 32'h1) begin
      errors++; $display("FAIL bp_1 got rdy=%b %h exp rdy=1 1", req_ready, rdata); end
    set_req(1, 0, 32'h44, 32'h0, 4'h0); tick();
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || rdata !== 32'h1) begin
      errors++; $display("FAIL bp_full got rdy=%b v=%b %h exp rdy=0 v=1 1", req_ready, resp_valid, rdata); end
    set_req(1, 0, 32'h48, 32'h0, 4'h0); tick();
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || rdata !== 32'h1 || err !== 1'b0) begin
      errors++; $display("FAIL bp_hold got rdy=%b v=%b %h/%b exp rdy=0 v=1 1/0", req_ready, resp_valid, rdata, err); end
    resp_ready = 1'b1; tick();
    checks++; if (req_ready !== 1'b1 || rdata !== 32'h2) begin
      errors++; $display("FAIL bp_pop1 got rdy=%b %h exp rdy=1 2", req_ready, rdata); end
    resp_ready = 1'b0; tick();
    checks++; if (req_ready !== 1'b0 || rdata !== 32'h2) begin
      errors++; $display("FAIL bp_third_acc got rdy=%b %h exp rdy=0 2", req_ready, rdata); end
    set_req(0, 0, 32'h0, 32'h0, 4'h0);
    resp_ready = 1'b1; tick();
    checks++; if (req_ready !== 1'b1 || rdata !== 32'h3) begin
      errors++; $display("FAIL bp_pop2 got rdy=%b %h exp rdy=1 3", req_ready, rdata); end
    tick();
    checks++; if (resp_valid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL bp_drain got v=%b %h exp v=0 0", resp_valid, rdata); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h1; exp_data[1] = 32'h2; exp_data[2] = 32'h3;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready); end
      set_req(1, 0, 32'h40 + 32'(4 * (i % 3)), 32'h0, 4'h0);
      tick();
      checks++; if (resp_valid !== 1'b1 || rdata !== exp_data[i % 3]) begin
        errors++; $display("FAIL b2b_resp[%0d] got v=%b %h exp v=1 %h", i, resp_valid, rdata, exp_data[i % 3]); end
    end
    set_req(0, 0, 32'h0, 32'h0, 4'h0); tick(); tick();
  endtask

  task automatic test_reset_mid;
    resp_ready = 1'b0;
    set_req(1, 0, 32'h40, 32'h0, 4'h0); tick();
    set_req(1, 0, 32'h44, 32'h0, 4'h0); tick();
    set_req(0, 0, 32'h0, 32'h0, 4'h0);
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got rdy=%b v=%b exp 0 1", req_ready, resp_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL mid_rst got v=%b rdy=%b %h/%b exp 0 0 0/0", resp_valid, req_ready, rdata, err); end
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release got rdy=%b v=%b exp 1 0", req_ready, resp_valid); end
    set_req(1, 0, 32'h20, 32'h0, 4'h0); tick();
    checks++; if (rdata !== 32'hAA22CC44) begin
      errors++; $display("FAIL mid_keep20 got %h exp aa22cc44", rdata); end
    set_req(1, 0, 32'h10, 32'h0, 4'h0); tick();
    checks++; if (rdata !== 32'h12345678) begin
      errors++; $display("FAIL mid_keep10 got %h exp 12345678", rdata); end
    set_req(0, 0, 32'h0, 32'h0, 4'h0); tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rice_bus_memory_responder.md
RICE_BUS_MEMORY_RESPONDER -- requirements
Module: rice_bus_memory_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, power of two, ≥8.
REQ-003 SHALL have parameter BASE_ADDRESS, default 0: first byte address decoded.
REQ-004 SHALL have parameter SIZE, default 4096: bytes of storage, power of two, multiple of DATA_WIDTH/8.
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_request_valid  input  1  request present.
REQ-008 SHALL have port o_request_ready  output  1  request can be accepted.
REQ-009 SHALL have port i_address  input  ADDRESS_WIDTH  byte address.
REQ-010 SHALL have port i_write  input  1  1=write, 0=read.
REQ-011 SHALL have port i_write_data  input  DATA_WIDTH  write data.
REQ-012 SHALL have port i_strobe  input  DATA_WIDTH/8  byte-lane write enables.
REQ-013 SHALL have port o_response_valid  output  1  response present.
REQ-014 SHALL have port i_response_ready  input  1  requester accepts response.
REQ-015 SHALL have port o_read_data  output  DATA_WIDTH  read data.
REQ-016 SHALL have port o_error  output  1  access outside decoded range.

Function
REQ-017 SHALL accept a request on a rising edge where i_request_valid and o_request_ready are both 1; response handshake likewise uses o_response_valid and i_response_ready.
REQ-018 SHALL decode in-range as BASE_ADDRESS <= i_address < BASE_ADDRESS+SIZE; word index = (i_address-BASE_ADDRESS) >> log2(DATA_WIDTH/8); low address bits ignored.
REQ-019 SHALL, on accepted in-range write, update exactly the byte lanes with i_strobe set at that edge; response: o_read_data=0, o_error=0.
REQ-020 SHALL, on accepted in-range read, capture the addressed word at the accept edge; response: o_read_data=word, o_error=0.
REQ-021 SHALL, on accepted out-of-range request, leave storage unchanged; response: o_read_data=0, o_error=1.
REQ-022 SHALL return a read reflecting a write accepted on any earlier edge, including the immediately preceding one.
REQ-023 SHALL queue responses in a 2-entry in-order FIFO; exactly one response per accepted request.
REQ-024 SHALL assert o_response_valid no earlier than the cycle after acceptance (latency 1) when the FIFO was empty or popping.
REQ-025 SHALL drive o_request_ready = (FIFO count != 2), registered, with no combinational path from any input.
REQ-026 SHALL keep count unchanged on simultaneous push and pop; sustain one request per cycle while i_response_ready is held 1.
REQ-027 SHALL hold o_response_valid, o_read_data and o_error stable while o_response_valid=1 and i_response_ready=0.
REQ-028 SHALL drive o_read_data=0 and o_error=0 when o_response_valid=0.
REQ-029 SHALL, if i_strobe=0 on a write, update no bytes yet still respond normally.

Reset
REQ-030 SHALL, while i_rst=1, force FIFO count=0, o_response_valid=0, o_request_ready=0, o_read_data=0, o_error=0.
REQ-031 SHALL assert o_request_ready=1 from the first cycle after i_rst deasserts.
REQ-032 SHALL discard queued responses on reset mid-operation; storage contents are not reset and retain prior values.

Verification
REQ-033 Write 0x12345678 to 0x10 strobe 0xF, then read 0x10 -> responses (0,0) then (0x12345678,0), read response valid 1 cycle after acceptance.
REQ-034 Word 0x20 = 0xAABBCCDD; write 0x11223344 strobe 0x5; read -> 0xAA22CC44.
REQ-035 Read address BASE_ADDRESS+SIZE -> o_error=1, o_read_data=0, storage unchanged on re-read of last word.
REQ-036 Three back-to-back reads with i_response_ready=0 -> o_request_ready falls after 2 acceptances; third accepted only after first pop; responses in order.
REQ-037 Continuous requests with i_response_ready=1 -> one accept and one response per cycle, o_request_ready never drops.
REQ-038 Assert i_rst with 2 queued responses -> o_response_valid=0 immediately; after release, earlier-written data still readable.
